// File: rtl/riscv_dmem_responder_if.sv
// Request/response bus between the core's load/store port and the data-memory responder.
// The master modport is the core side; the slave modport is the memory side.
interface riscv_dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/riscv_dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store, waits WAIT_CYCLES, then
// answers with extended read data or a store ack plus an error flag.
module riscv_dmem_responder #(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input logic                   clk,
   input logic                   rst,
   riscv_dmem_responder_if.slave bus
);
   localparam int unsigned IDXW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam bit          DIRECT    = (WAIT_CYCLES == 0);
   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic        l_we;
   logic [1:0]  l_size;
   logic        l_uns;
   logic [31:0] l_addr;
   logic [31:0] l_wdata;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   logic [31:0] mem [DEPTH];

   logic        accept;
   logic        go_resp;
   logic        acc_we;
   logic [1:0]  acc_size;
   logic        acc_uns;
   logic [31:0] acc_addr;
   logic [31:0] acc_wdata;
   logic        acc_err;
   logic [IDXW-1:0] idx;
   logic [31:0] word;
   logic [31:0] shifted;
   logic [31:0] load_val;
   logic [3:0]  be;
   logic [31:0] wd;
   logic [31:0] merged;
   logic        commit;

   assign accept = (state == IDLE) && req_ready && bus.req_valid;

   // With no wait cycles the access happens on the accept edge itself, so it must
   // read the live request fields rather than the latched copy.
   assign go_resp   = DIRECT ? accept : ((state == WAIT) && (cnt == 4'd1));
   assign acc_we    = DIRECT ? bus.req_we       : l_we;
   assign acc_size  = DIRECT ? bus.req_size     : l_size;
   assign acc_uns   = DIRECT ? bus.req_unsigned : l_uns;
   assign acc_addr  = DIRECT ? bus.req_addr     : l_addr;
   assign acc_wdata = DIRECT ? bus.req_wdata    : l_wdata;

   always_comb begin
      acc_err = (acc_size == 2'b11)
             || ((acc_size == 2'b01) && acc_addr[0])
             || ((acc_size == 2'b10) && (acc_addr[1:0] != 2'b00))
             || ({2'b00, acc_addr[31:2]} >= DEPTH);
      idx     = acc_addr[IDXW+1:2];
      word    = mem[idx];
      shifted = word >> {acc_addr[1:0], 3'b000};

      case (acc_size)
         2'b00:   load_val = acc_uns ? {24'h0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
         2'b01:   load_val = acc_uns ? {16'h0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
         default: load_val = word;
      endcase

      case (acc_size)
         2'b00: begin
            be = 4'b0001 << acc_addr[1:0];
            wd = {4{acc_wdata[7:0]}};
         end
         2'b01: begin
            be = acc_addr[1] ? 4'b1100 : 4'b0011;
            wd = {2{acc_wdata[15:0]}};
         end
         default: begin
            be = 4'b1111;
            wd = acc_wdata;
         end
      endcase

      merged = word;
      for (int unsigned i = 0; i < 4; i++) begin
         if (be[i]) merged[8*i +: 8] = wd[8*i +: 8];
      end

      commit = go_resp && acc_we && !acc_err && !rst;
   end

   always_ff @(posedge clk) begin
      if (commit) mem[idx] <= merged;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         l_we      <= 1'b0;
         l_size    <= '0;
         l_uns     <= 1'b0;
         l_addr    <= '0;
         l_wdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  l_we      <= bus.req_we;
                  l_size    <= bus.req_size;
                  l_uns     <= bus.req_unsigned;
                  l_addr    <= bus.req_addr;
                  l_wdata   <= bus.req_wdata;
                  req_ready <= 1'b0;
                  state     <= WAIT;
                  cnt       <= WAIT_INIT;
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
                  rsp_valid <= 1'b0;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase

         // Entry into RESP overrides the per-state updates above, whether it comes
         // from the last WAIT cycle or straight from IDLE.
         if (go_resp) begin
            state     <= RESP;
            cnt       <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= acc_err;
            rsp_rdata <= (acc_we || acc_err) ? '0 : load_val;
         end
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_rdata = rsp_rdata;
   assign bus.rsp_err   = rsp_err;
endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Bench for riscv_dmem_responder: vector table with a response scoreboard on a
// WAIT_CYCLES=2 instance, plus hand sequences and a WAIT_CYCLES=0 instance.
module tb_riscv_dmem_responder;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        sel;
   logic        t_valid;
   logic        t_we;
   logic [1:0]  t_size;
   logic        t_uns;
   logic [31:0] t_addr;
   logic [31:0] t_wdata;
   logic        t_rsp_ready;

   riscv_dmem_responder_if a_if ();
   riscv_dmem_responder_if b_if ();

   assign a_if.req_valid    = t_valid & ~sel;
   assign b_if.req_valid    = t_valid & sel;
   assign a_if.req_we       = t_we;
   assign b_if.req_we       = t_we;
   assign a_if.req_size     = t_size;
   assign b_if.req_size     = t_size;
   assign a_if.req_unsigned = t_uns;
   assign b_if.req_unsigned = t_uns;
   assign a_if.req_addr     = t_addr;
   assign b_if.req_addr     = t_addr;
   assign a_if.req_wdata    = t_wdata;
   assign b_if.req_wdata    = t_wdata;
   assign a_if.rsp_ready    = t_rsp_ready;
   assign b_if.rsp_ready    = t_rsp_ready;

   riscv_dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (a_if.slave)
   );

   riscv_dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (b_if.slave)
   );

   logic        o_req_ready;
   logic        o_rsp_valid;
   logic [31:0] o_rsp_rdata;
   logic        o_rsp_err;
   assign o_req_ready = sel ? b_if.req_ready : a_if.req_ready;
   assign o_rsp_valid = sel ? b_if.rsp_valid : a_if.rsp_valid;
   assign o_rsp_rdata = sel ? b_if.rsp_rdata : a_if.rsp_rdata;
   assign o_rsp_err   = sel ? b_if.rsp_err   : a_if.rsp_err;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[$];

   int unsigned nvec = 0;
   int unsigned nerr = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      t_valid = 1'b1;
      t_we    = v.we;
      t_size  = v.size;
      t_uns   = v.uns;
      t_addr  = v.addr;
      t_wdata = v.wdata;
   endtask

   function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_err);
      vec_t v;
      v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.exp_rdata = exp_rdata; v.exp_err = exp_err;
      return v;
   endfunction

   // Waits at negedges for req_ready; leaves the bench at a negedge.
   task automatic wait_ready(input string name, output bit ok);
      int unsigned n = 0;
      while (!o_req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      ok = o_req_ready;
      if (!ok) chk({name, " accept timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_rsp(input string name, output bit ok);
      int unsigned n = 0;
      while (!o_rsp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      ok = o_rsp_valid;
      if (!ok) chk({name, " response timeout"}, 32'd0, 32'd1);
   endtask

   task automatic pop_cmp(input string name);
      exp_t e;
      if (sb.size() == 0) begin
         chk({name, " unexpected response"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk({name, " rdata"}, o_rsp_rdata, e.rdata);
         chk({name, " err"}, {31'd0, o_rsp_err}, {31'd0, e.err});
      end
   endtask

   task automatic xact(input vec_t v, input string name);
      bit ok;
      int unsigned edges;
      @(negedge clk);
      t_rsp_ready = 1'b1;
      drive(v);
      wait_ready(name, ok);
      if (!ok) begin
         t_valid = 1'b0;
         return;
      end
      sb.push_back('{v.exp_rdata, v.exp_err});
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      t_valid = 1'b0;
      while (!o_rsp_valid && edges < 50) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      chk({name, " latency"}, edges, sel ? 32'd1 : 32'd3);
      if (o_rsp_valid) pop_cmp(name);
      else void'(sb.pop_back());
      @(posedge clk);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int unsigned nrsp;

      rst = 1'b1; sel = 1'b0; t_valid = 1'b0; t_we = 1'b0; t_size = 2'b00;
      t_uns = 1'b0; t_addr = '0; t_wdata = '0; t_rsp_ready = 1'b1;

      tbl.push_back(mk(1, 2'b10, 0, 32'h10,  32'hdeadc0de, 32'h0,        0));
      tbl.push_back(mk(0, 2'b10, 0, 32'h10,  32'h0,        32'hdeadc0de, 0));
      tbl.push_back(mk(1, 2'b10, 0, 32'h10,  32'h0,        32'h0,        0));
      tbl.push_back(mk(1, 2'b00, 0, 32'h12,  32'h80,       32'h0,        0));
      tbl.push_back(mk(0, 2'b00, 0, 32'h12,  32'h0,        32'hffffff80, 0));
      tbl.push_back(mk(0, 2'b00, 1, 32'h12,  32'h0,        32'h00000080, 0));
      tbl.push_back(mk(0, 2'b10, 0, 32'h10,  32'h0,        32'h00800000, 0));
      tbl.push_back(mk(1, 2'b01, 0, 32'h10,  32'h1234beef, 32'h0,        0));
      tbl.push_back(mk(0, 2'b01, 0, 32'h10,  32'h0,        32'hffffbeef, 0));
      tbl.push_back(mk(0, 2'b01, 1, 32'h10,  32'h0,        32'h0000beef, 0));
      tbl.push_back(mk(0, 2'b10, 0, 32'h10,  32'h0,        32'h0080beef, 0));
      tbl.push_back(mk(0, 2'b10, 0, 32'h11,  32'h0,        32'h0,        1));
      tbl.push_back(mk(0, 2'b01, 0, 32'h13,  32'h0,        32'h0,        1));
      tbl.push_back(mk(0, 2'b11, 0, 32'h10,  32'h0,        32'h0,        1));
      tbl.push_back(mk(0, 2'b10, 0, 32'h400, 32'h0,        32'h0,        1));
      tbl.push_back(mk(1, 2'b10, 0, 32'h11,  32'hffffffff, 32'h0,        1));
      tbl.push_back(mk(1, 2'b00, 0, 32'h401, 32'hffffffff, 32'h0,        1));
      tbl.push_back(mk(0, 2'b10, 0, 32'h10,  32'h0,        32'h0080beef, 0));
      tbl.push_back(mk(1, 2'b01, 0, 32'h12,  32'h00008001, 32'h0,        0));
      tbl.push_back(mk(0, 2'b01, 0, 32'h12,  32'h0,        32'hffff8001, 0));
      tbl.push_back(mk(0, 2'b10, 0, 32'h10,  32'h0,        32'h8001beef, 0));
      tbl.push_back(mk(1, 2'b10, 0, 32'h3fc, 32'ha5a55a5a, 32'h0,        0));
      tbl.push_back(mk(0, 2'b00, 1, 32'h3ff, 32'h0,        32'h000000a5, 0));
      tbl.push_back(mk(0, 2'b00, 0, 32'h3ff, 32'h0,        32'hffffffa5, 0));
      tbl.push_back(mk(1, 2'b10, 0, 32'h10,  32'hdeadc0de, 32'h0,        0));
      tbl.push_back(mk(1, 2'b10, 0, 32'h20,  32'h0,        32'h0,        0));
      tbl.push_back(mk(1, 2'b10, 0, 32'h24,  32'h0,        32'h0,        0));

      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         sel = (d == 1);
         #1;
         chk("reset req_ready", {31'd0, o_req_ready}, 32'd1);
         chk("reset rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
         chk("reset rsp_rdata", o_rsp_rdata, 32'd0);
         chk("reset rsp_err",   {31'd0, o_rsp_err}, 32'd0);
      end
      sel = 1'b0;
      rst = 1'b0;

      foreach (tbl[i]) xact(tbl[i], $sformatf("vec%0d", i));

      // Backpressure: response held for 5 cycles while a second request waits.
      @(negedge clk);
      t_rsp_ready = 1'b0;
      drive(mk(0, 2'b10, 0, 32'h10, 32'h0, 32'h0, 0));
      wait_ready("bp", ok);
      sb.push_back('{32'hdeadc0de, 1'b0});
      @(posedge clk);
      @(negedge clk);
      drive(mk(0, 2'b10, 0, 32'h3fc, 32'h0, 32'h0, 0));
      wait_rsp("bp", ok);
      for (int i = 0; i < 5; i++) begin
         chk("bp rsp_valid", {31'd0, o_rsp_valid}, 32'd1);
         chk("bp rsp_rdata", o_rsp_rdata, 32'hdeadc0de);
         chk("bp rsp_err",   {31'd0, o_rsp_err}, 32'd0);
         chk("bp req_ready", {31'd0, o_req_ready}, 32'd0);
         @(negedge clk);
      end
      t_rsp_ready = 1'b1;
      pop_cmp("bp first");
      @(posedge clk);
      @(negedge clk);
      chk("bp idle req_ready", {31'd0, o_req_ready}, 32'd1);
      chk("bp idle rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
      sb.push_back('{32'ha5a55a5a, 1'b0});
      @(posedge clk);
      @(negedge clk);
      t_valid = 1'b0;
      chk("bp second accepted", {31'd0, o_req_ready}, 32'd0);
      wait_rsp("bp second", ok);
      if (ok) pop_cmp("bp second");
      @(posedge clk);

      // Reset during WAIT drops an uncommitted store.
      @(negedge clk);
      drive(mk(1, 2'b10, 0, 32'h20, 32'h12345678, 32'h0, 0));
      wait_ready("rst wait", ok);
      @(posedge clk);
      @(negedge clk);
      t_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst wait req_ready", {31'd0, o_req_ready}, 32'd1);
      chk("rst wait rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
      xact(mk(0, 2'b10, 0, 32'h20, 32'h0, 32'h0, 0), "rst wait lw 0x20");
      xact(mk(0, 2'b10, 0, 32'h10, 32'h0, 32'hdeadc0de, 0), "rst wait lw 0x10");

      // Reset during RESP keeps the committed store.
      @(negedge clk);
      t_rsp_ready = 1'b0;
      drive(mk(1, 2'b10, 0, 32'h24, 32'hcafef00d, 32'h0, 0));
      wait_ready("rst resp", ok);
      @(posedge clk);
      @(negedge clk);
      t_valid = 1'b0;
      wait_rsp("rst resp", ok);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst resp req_ready", {31'd0, o_req_ready}, 32'd1);
      chk("rst resp rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
      xact(mk(0, 2'b10, 0, 32'h24, 32'h0, 32'hcafef00d, 0), "rst resp lw 0x24");

      // Zero-wait instance: one response every two edges with requests held.
      sel = 1'b1;
      xact(mk(1, 2'b10, 0, 32'h0, 32'h55aa00ff, 32'h0, 0), "w0 sw");
      xact(mk(0, 2'b01, 0, 32'h2, 32'h0, 32'h000055aa, 0), "w0 lh");
      @(negedge clk);
      t_rsp_ready = 1'b1;
      drive(mk(0, 2'b10, 0, 32'h0, 32'h0, 32'h0, 0));
      nrsp = 0;
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("w0 req_ready c%0d", i), {31'd0, o_req_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
         chk($sformatf("w0 rsp_valid c%0d", i), {31'd0, o_rsp_valid}, (i % 2 == 1) ? 32'd1 : 32'd0);
         if (o_req_ready) sb.push_back('{32'h55aa00ff, 1'b0});
         if (o_rsp_valid) begin
            nrsp++;
            pop_cmp($sformatf("w0 rsp c%0d", i));
         end
         @(negedge clk);
      end
      t_valid = 1'b0;
      chk("w0 response count", nrsp, 32'd5);
      repeat (2) @(negedge clk);
      sb.delete();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
